// File: rtl/axi_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
// The arbiter takes the master modport; the requesters/FIFO model take slave.
interface axi_wr_arbiter_if #(
  parameter int NCH   = 4,
  parameter int DSIZE = 8,
  parameter int IDW   = 2
);
  logic [NCH-1:0]       i_req_vld;
  logic [NCH*DSIZE-1:0] i_req_data;
  logic [NCH-1:0]       i_req_last;
  logic [NCH-1:0]       o_req_rdy;
  logic                 o_aw_vld;
  logic [DSIZE-1:0]     o_aw_data;
  logic                 o_aw_last;
  logic [IDW-1:0]       o_aw_id;
  logic                 i_aw_rdy;
  logic [NCH-1:0]       o_grant;
  logic                 o_busy;

  modport master (
    input  i_req_vld, i_req_data, i_req_last, i_aw_rdy,
    output o_req_rdy, o_aw_vld, o_aw_data, o_aw_last, o_aw_id, o_grant, o_busy
  );

  modport slave (
    output i_req_vld, i_req_data, i_req_last, i_aw_rdy,
    input  o_req_rdy, o_aw_vld, o_aw_data, o_aw_last, o_aw_id, o_grant, o_busy
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin burst arbiter: locks one requester per burst onto the FIFO
// write port, forcing an end of grant after MAX_BURST beats.
module axi_wr_arbiter #(
  parameter int NCH       = 4,
  parameter int DSIZE     = 8,
  parameter int IDW       = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                aw_clk,
  input  logic                aw_rst,
  axi_wr_arbiter_if.master    bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [CW-1:0]    beat_cnt_reg;
  logic [NCH-1:0]   grant_reg;

  logic             active;
  logic [2*NCH-1:0] req_dbl;
  logic [2*NCH-1:0] req_rot;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   ptr_next;
  logic [DSIZE-1:0] lane_data [NCH];
  logic [DSIZE-1:0] data_sel;
  logic             vld_sel;
  logic             last_sel;
  logic             accept;
  logic             burst_end;

  // Everything outward-facing is forced low while reset is held.
  assign active = (state_reg == XFER) && !aw_rst;

  // Rotating the doubled request vector puts rr_ptr at bit 0, so the
  // lowest set bit of the rotated vector is the round-robin winner.
  assign req_dbl = {bus.i_req_vld, bus.i_req_vld};
  assign req_rot = req_dbl >> rr_ptr_reg;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!pick_found && req_rot[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'((int'(rr_ptr_reg) + j) % NCH);
      end
    end
  end

  assign ptr_next = IDW'((int'(id_reg) + 1) % NCH);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      assign lane_data[gi]     = bus.i_req_data[gi*DSIZE +: DSIZE];
      assign bus.o_req_rdy[gi] = active && grant_reg[gi] && bus.i_aw_rdy;
    end
  endgenerate

  always_comb begin
    data_sel = '0;
    vld_sel  = 1'b0;
    last_sel = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (grant_reg[k]) begin
        data_sel = data_sel | lane_data[k];
        vld_sel  = vld_sel  | bus.i_req_vld[k];
        last_sel = last_sel | bus.i_req_last[k];
      end
    end
  end

  assign bus.o_aw_vld  = active && vld_sel;
  assign bus.o_aw_data = active ? data_sel : '0;
  assign bus.o_aw_last = active && (last_sel || (beat_cnt_reg == LAST_CNT));
  assign bus.o_aw_id   = active ? id_reg : '0;
  assign bus.o_grant   = active ? grant_reg : '0;
  assign bus.o_busy    = active;

  assign accept    = bus.o_aw_vld && bus.i_aw_rdy;
  assign burst_end = accept && bus.o_aw_last;

  always_ff @(posedge aw_clk) begin
    if (aw_rst) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      id_reg       <= '0;
      beat_cnt_reg <= '0;
      grant_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg    <= XFER;
            grant_reg    <= {{(NCH-1){1'b0}}, 1'b1} << pick_idx;
            id_reg       <= pick_idx;
            beat_cnt_reg <= '0;
          end
        end
        XFER: begin
          // A stalled or absent requester simply holds the grant here.
          if (burst_end) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            rr_ptr_reg   <= ptr_next;
            beat_cnt_reg <= '0;
          end else if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: per-channel beat queues feed the DUT and
// a scoreboard of expected beats is checked at every accepted FIFO write.
module tb_axi_wr_arbiter;
  localparam int NCH = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] hold;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   cyc     = 0;
  int   base;
  int   lim;

  beat_t chq [NCH][$];
  exp_t  exp_q[$];
  int    acc_cyc[$];
  logic  pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  axi_wr_arbiter_if #(.NCH(4), .DSIZE(8), .IDW(2)) bus ();

  axi_wr_arbiter #(.NCH(4), .DSIZE(8), .IDW(2), .MAX_BURST(16)) dut (
    .aw_clk (clk),
    .aw_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int ch, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    chq[ch].push_back(b);
  endtask

  task automatic expect_beat(input int ch, input logic [7:0] d, input logic l);
    exp_t e;
    e.id   = 2'(ch);
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input bit want_idle, input string tag);
    int k;
    k = 0;
    while (k < budget && (exp_q.size() != 0 || (want_idle && bus.o_busy))) begin
      tick();
      k++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    if (want_idle) chk({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int k;
    k = 0;
    while (k < budget && !bus.o_busy) begin
      tick();
      k++;
    end
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
  endtask

  task automatic do_reset();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    for (int k = 0; k < NCH; k++) chq[k].delete();
    hold = '0;
    bus.i_aw_rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    acc_cyc.delete();
  endtask

  // Requester model: holds the head beat until it is accepted.
  initial begin
    logic [NCH-1:0] acc;
    bus.i_req_vld  = '0;
    bus.i_req_data = '0;
    bus.i_req_last = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NCH; k++) acc[k] = bus.o_req_rdy[k] && bus.i_req_vld[k] && !rst;
      @(posedge clk);
      #1;
      for (int k = 0; k < NCH; k++) begin
        if (acc[k] && chq[k].size() > 0) void'(chq[k].pop_front());
        if (chq[k].size() > 0 && !hold[k]) begin
          bus.i_req_vld[k]          = 1'b1;
          bus.i_req_data[k*8 +: 8]  = chq[k][0].data;
          bus.i_req_last[k]         = chq[k][0].last;
        end else begin
          bus.i_req_vld[k]          = 1'b0;
          bus.i_req_data[k*8 +: 8]  = 8'h00;
          bus.i_req_last[k]         = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every beat that will be written at the next edge is compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && bus.o_aw_vld && bus.i_aw_rdy) begin
        n_acc++;
        acc_cyc.push_back(cyc);
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("[TB] beat id=%0d data=%02h last=%0d", bus.o_aw_id, bus.o_aw_data, bus.o_aw_last);
          chk("beat_id",    32'(bus.o_aw_id),   32'(e.id));
          chk("beat_data",  32'(bus.o_aw_data), 32'(e.data));
          chk("beat_last",  32'(bus.o_aw_last), 32'(e.last));
          chk("beat_grant", 32'(bus.o_grant),   32'(4'b0001 << e.id));
          chk("beat_rdy",   32'(bus.o_req_rdy), 32'(4'b0001 << e.id));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hold = '0;
    bus.i_aw_rdy = 1'b1;
    tick();
    tick();
    chk("rst_aw_vld", 32'(bus.o_aw_vld),  32'd0);
    chk("rst_req_rdy", 32'(bus.o_req_rdy), 32'd0);
    chk("rst_grant",  32'(bus.o_grant),   32'd0);
    chk("rst_busy",   32'(bus.o_busy),    32'd0);
    chk("rst_aw_id",  32'(bus.o_aw_id),   32'd0);
    chk("rst_aw_last", 32'(bus.o_aw_last), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_grant", 32'(bus.o_grant), 32'd0);

    // Single requester ch2, three beats.
    send(2, 8'hA1, 1'b0); send(2, 8'hA2, 1'b0); send(2, 8'hA3, 1'b1);
    expect_beat(2, 8'hA1, 1'b0); expect_beat(2, 8'hA2, 1'b0); expect_beat(2, 8'hA3, 1'b1);
    lim = 0;
    while (lim < 20 && !bus.i_req_vld[2]) begin tick(); lim++; end
    chk("t1_req_seen", 32'(bus.i_req_vld[2]), 32'd1);
    chk("t1_vld_at_req", 32'(bus.o_aw_vld), 32'd0);
    tick();
    chk("t1_latency", 32'(bus.o_aw_vld), 32'd1);
    chk("t1_grant", 32'(bus.o_grant), 32'h4);
    wait_done(50, 1'b1, "t1");
    chk("t1_rr_ptr", 32'(dut.rr_ptr_reg), 32'd3);
    chk("t1_grant_idle", 32'(bus.o_grant), 32'd0);

    // Round-robin fairness with 1-beat bursts on all channels.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) begin
        send(c, 8'(8'h30 + 16 * r + c), 1'b1);
        expect_beat(c, 8'(8'h30 + 16 * r + c), 1'b1);
      end
    end
    wait_done(100, 1'b1, "t2");
    chk("t2_count", 32'(acc_cyc.size()), 32'd8);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

    // MAX_BURST cut: 20 beats on ch0, no requester last.
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      send(0, 8'(i), 1'b0);
      expect_beat(0, 8'(i), (i == 16) ? 1'b1 : 1'b0);
    end
    wait_done(100, 1'b0, "t3");
    chk("t3_count", 32'(acc_cyc.size()), 32'd20);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t3_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), (i == 16) ? 32'd2 : 32'd1);
    chk("t3_grant_held", 32'(bus.o_grant), 32'h1);
    chk("t3_busy_held", 32'(bus.o_busy), 32'd1);

    // Backpressure on a 4-beat ch1 burst.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1, 8'(8'hB0 + i), (i == 3) ? 1'b1 : 1'b0);
      expect_beat(1, 8'(8'hB0 + i), (i == 3) ? 1'b1 : 1'b0);
    end
    base = n_acc;
    wait_busy(20, "t4");
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      bus.i_aw_rdy = pat[i];
      #1;
      chk("t4_rdy_mirror", 32'(bus.o_req_rdy), 32'({2'b00, pat[i], 1'b0}));
      chk("t4_grant", 32'(bus.o_grant), 32'h2);
      if (i == 6) begin
        chk("t4_beat_cnt", 32'(dut.beat_cnt_reg), 32'd3);
        chk("t4_last", 32'(bus.o_aw_last), 32'd1);
      end
    end
    bus.i_aw_rdy = 1'b1;
    wait_done(50, 1'b1, "t4");
    chk("t4_accepted", 32'(n_acc - base), 32'd4);

    // Requester gap on ch3 while ch0 waits.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(3, 8'(8'hC1 + i), (i == 3) ? 1'b1 : 1'b0);
      expect_beat(3, 8'(8'hC1 + i), (i == 3) ? 1'b1 : 1'b0);
    end
    expect_beat(0, 8'hD0, 1'b1);
    base = n_acc;
    wait_busy(20, "t5");
    send(0, 8'hD0, 1'b1);
    lim = 0;
    while (lim < 20 && n_acc < base + 1) begin tick(); lim++; end
    chk("t5_first_beat", 32'(n_acc - base), 32'd1);
    hold[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_gap_grant", 32'(bus.o_grant), 32'h8);
      chk("t5_gap_vld", 32'(bus.o_aw_vld), 32'd0);
    end
    hold[3] = 1'b0;
    wait_done(50, 1'b1, "t5");

    // Reset in the middle of a ch1 burst, after rr_ptr has moved to 3.
    do_reset();
    send(2, 8'hE0, 1'b1);
    expect_beat(2, 8'hE0, 1'b1);
    wait_done(50, 1'b1, "t6a");
    chk("t6_rr_before", 32'(dut.rr_ptr_reg), 32'd3);
    for (int i = 0; i < 4; i++) send(1, 8'(8'hF1 + i), (i == 3) ? 1'b1 : 1'b0);
    expect_beat(1, 8'hF1, 1'b0);
    base = n_acc;
    wait_busy(20, "t6");
    lim = 0;
    while (lim < 20 && n_acc < base + 1) begin tick(); lim++; end
    chk("t6_first_beat", 32'(n_acc - base), 32'd1);
    rst = 1'b1;
    send(0, 8'hA0, 1'b1);
    send(3, 8'hA3, 1'b1);
    #1;
    chk("t6_rst_vld", 32'(bus.o_aw_vld), 32'd0);
    chk("t6_rst_rdy", 32'(bus.o_req_rdy), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_grant_after", 32'(bus.o_grant), 32'd0);
    chk("t6_busy_after", 32'(bus.o_busy), 32'd0);
    chk("t6_rr_after", 32'(dut.rr_ptr_reg), 32'd0);
    expect_beat(0, 8'hA0, 1'b1);
    expect_beat(1, 8'hF2, 1'b0);
    expect_beat(1, 8'hF3, 1'b0);
    expect_beat(1, 8'hF4, 1'b1);
    expect_beat(3, 8'hA3, 1'b1);
    wait_done(100, 1'b1, "t6");
    chk("end_grant", 32'(bus.o_grant), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_wr_arbiter.md
Name: axi_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the write port of the AXI-style async FIFO among NCH requesters in the write clock domain.
- Each requester presents a valid/ready/last stream. The arbiter locks one requester for a whole burst, then rotates priority.
- Output drives the FIFO write side (vld/data/rdy) and carries the requester ID for downstream tagging.

Parameters:
- NCH, 4, number of requesters (2..16).
- DSIZE, 8, data width per beat.
- IDW, 2, width of o_aw_id; must satisfy 2^IDW >= NCH.
- MAX_BURST, 16, maximum beats per grant; the grant is forced to end after this many beats even without last (1..65535).

Ports:
- aw_clk  in  1  write-side clock; all logic is on its rising edge.
- aw_rst  in  1  synchronous reset, active-high.
- i_req_vld  in  NCH  per-requester beat valid.
- i_req_data  in  NCH*DSIZE  per-requester data; requester k occupies bits [k*DSIZE +: DSIZE].
- i_req_last  in  NCH  per-requester end-of-burst flag, qualified by i_req_vld.
- o_req_rdy  out  NCH  per-requester beat accepted.
- o_aw_vld  out  1  beat valid toward FIFO write side.
- o_aw_data  out  DSIZE  beat data.
- o_aw_last  out  1  last beat of current grant (requester last or MAX_BURST reached).
- o_aw_id  out  IDW  index of granted requester.
- i_aw_rdy  in  1  FIFO write side ready.
- o_grant  out  NCH  one-hot current grant; all zero when idle.
- o_busy  out  1  high while in XFER.

Behaviour:
- Reset (aw_rst=1 at an edge):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant=0.
  - All outputs are 0 during and after reset until a grant is issued.
  - Reset mid-burst aborts the burst. No beat is accepted in the reset cycle: o_req_rdy=0 and o_aw_vld=0 while aw_rst=1.
- States: IDLE, XFER.
- IDLE:
  - Search i_req_vld starting at index rr_ptr, ascending with wrap mod NCH.
  - The first set bit g wins. Register grant=onehot(g), o_aw_id=g, beat_cnt=0, and go to XFER next cycle.
  - If no request, stay in IDLE.
  - Arbitration latency is 1 cycle from request to first o_aw_vld.
- XFER, combinational datapath from requester g:
  - o_aw_vld = i_req_vld[g]
  - o_aw_data = i_req_data[g]
  - o_req_rdy[g] = i_aw_rdy
  - o_req_rdy of every other requester = 0
- Beat accepted when o_aw_vld && i_aw_rdy; beat_cnt increments on each accepted beat.
- o_aw_last = i_req_last[g] || (beat_cnt == MAX_BURST-1).
- Burst end: an accepted beat with o_aw_last=1. Next state is IDLE, rr_ptr=(g+1) mod NCH, grant cleared.
- There is one mandatory IDLE cycle between grants (no back-to-back arbitration).
- A requester dropping i_req_vld mid-burst keeps the grant; the arbiter waits with no timeout.
- i_aw_rdy low stalls the burst; data and vld pass through unchanged.
- Requests from non-granted channels are ignored until IDLE.
- Simultaneous requests in IDLE are resolved strictly by rr_ptr rotation, so no starvation occurs. Worst-case wait is (NCH-1) grants.
- beat_cnt is sized ceil(log2(MAX_BURST+1)) bits and never wraps, because a forced last ends the grant at MAX_BURST-1.
- MAX_BURST=1: every beat is last, so grants rotate every beat.

Test Plan:
- Single requester: NCH=4, only ch2 sends 3 beats 0xA1,0xA2,0xA3 with last on the third, i_aw_rdy=1.
  - Required: first o_aw_vld one cycle after request.
  - Required: o_aw_id=2 and o_grant=4'b0100 for all three beats, o_aw_last on beat 3.
  - Required: IDLE follows, rr_ptr=3.
- Round-robin fairness: all 4 channels continuously request 1-beat bursts (last=1) from reset.
  - Required grant order: 0,1,2,3,0,1; exactly one beat every 2 cycles.
- MAX_BURST cut: MAX_BURST=16, ch0 sends 20 beats with no last.
  - Required: o_aw_last on beat 16, then grant returns to IDLE.
  - Required: with only ch0 requesting, ch0 is regranted for remaining beats 17-20.
- Backpressure: ch1 sends 4 beats, i_aw_rdy toggles 1,0,0,1,1,0,1.
  - Required: o_req_rdy[1] mirrors i_aw_rdy; exactly 4 beats are accepted with data order preserved.
  - Required: beat_cnt=3 at the last beat, grant held throughout.
- Requester gap: ch3 drops i_req_vld for 5 cycles mid-burst while ch0 requests.
  - Required: grant stays on ch3 (o_grant=4'b1000) and o_aw_vld=0 during the gap.
  - Required: ch0 is granted only after ch3's last.
- Reset mid-burst: assert aw_rst for 1 cycle during beat 2 of a 4-beat ch1 burst.
  - Required: o_aw_vld=0 and o_req_rdy=0 in the reset cycle; o_grant=0 and o_busy=0 next cycle.
  - Required: the next arbitration starts from rr_ptr=0.
